// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver; outputs registered, one clock behind state.
// No backpressure: free-running scan, digits snapshotted only at LOAD and frame wrap.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  typedef enum logic [1:0] {OFF, LOAD, SCAN} state_t;

  localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM    = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  state_t          state_q, state_d;
  logic [PW-1:0]   pres_q, pres_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] hold_q, hold_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            fd_q, fd_d;
  logic            blank;

  // Active-high {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    fd_d    = 1'b0;
    an_d    = 4'hF;
    seg_d   = SEG_OFF;
    blank   = 1'b0;

    case (state_q)
      OFF: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        hold_d  = {d3, d2, d1, d0};
        idx_d   = 2'd0;
        pres_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_d = OFF;
        end else if (pres_q == TERM) begin
          pres_d = '0;
          idx_d  = idx_q + 2'd1;
          // Frame wrap: take the next snapshot so a frame never mixes old and new digits.
          if (idx_q == 2'd3) begin
            hold_d = {d3, d2, d1, d0};
            fd_d   = 1'b1;
          end
        end else begin
          pres_d = pres_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    if (state_q == SCAN) begin
      blank = BLANK_LEADING && idx_q[0] && (hold_q[idx_q] == 4'd0);
      if (!blank) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = decode(hold_q[idx_q]) ^ {7{ACTIVE_LOW_SEG}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      pres_q  <= '0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      an_q    <= 4'hF;
      seg_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pres_q  <= pres_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three parameter variants on shared inputs,
// expected per-cycle outputs queued from vector table and popped each cycle.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] an, an_nb, an_ah;
  logic [6:0] seg, seg_nb, seg_ah;
  logic       fd, fd_nb, fd_ah;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1), .ACTIVE_LOW_SEG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an), .seg(seg), .frame_done(fd));

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0), .ACTIVE_LOW_SEG(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an_nb), .seg(seg_nb), .frame_done(fd_nb));

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1), .ACTIVE_LOW_SEG(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an(an_ah), .seg(seg_ah), .frame_done(fd_ah));

  typedef struct packed {
    logic [3:0][3:0] d;       // {d3,d2,d1,d0}
    logic [3:0][3:0] an;      // per slot, slot3..slot0
    logic [3:0][6:0] seg;
    logic [3:0][3:0] an_nb;
    logic [3:0][6:0] seg_nb;
    logic [3:0][6:0] seg_ah;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] an_nb;
    logic [6:0] seg_nb;
    logic [6:0] seg_ah;
    logic       fd;
  } exp_t;

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  vec_t rows[5];
  vec_t rnew;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int idx, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blank(input int n);
    exp_t e;
    e = '{an: 4'hF, seg: 7'h7F, an_nb: 4'hF, seg_nb: 7'h7F, seg_ah: 7'h00, fd: 1'b0};
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic push_entry(input vec_t r, input int s, input logic f);
    exp_t e;
    e.an     = r.an[s];
    e.seg    = r.seg[s];
    e.an_nb  = r.an_nb[s];
    e.seg_nb = r.seg_nb[s];
    e.seg_ah = r.seg_ah[s];
    e.fd     = f;
    sb_q.push_back(e);
  endtask

  task automatic push_frame(input vec_t r);
    for (int k = 0; k < 16; k++) push_entry(r, k / 4, (k == 15));
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step();
      e = sb_q.pop_front();
      chk("an",        popped, {3'b0, an},    {3'b0, e.an});
      chk("seg",       popped, seg,           e.seg);
      chk("an_nb",     popped, {3'b0, an_nb}, {3'b0, e.an_nb});
      chk("seg_nb",    popped, seg_nb,        e.seg_nb);
      chk("an_ah",     popped, {3'b0, an_ah}, {3'b0, e.an});
      chk("seg_ah",    popped, seg_ah,        e.seg_ah);
      chk("frame_done",popped, {6'b0, fd},    {6'b0, e.fd});
      chk("fd_nb_ah",  popped, {5'b0, fd_nb, fd_ah}, {5'b0, e.fd, e.fd});
      popped++;
    end
  endtask

  task automatic drive(input vec_t r);
    d0 = r.d[0]; d1 = r.d[1]; d2 = r.d[2]; d3 = r.d[3];
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_an"},  0, {3'b0, an},    7'b0001111);
    chk({nm, "_seg"}, 0, seg,           7'b1111111);
    chk({nm, "_fd"},  0, {6'b0, fd},    7'b0);
    chk({nm, "_an_ah"},  0, {3'b0, an_ah}, 7'b0001111);
    chk({nm, "_seg_ah"}, 0, seg_ah,        7'b0000000);
    chk({nm, "_seg_nb"}, 0, seg_nb,        7'b1111111);
  endtask

  initial begin
    // Basic digits 2,5,1,8
    rows[0] = '{d: {4'd2, 4'd5, 4'd1, 4'd8}, an: AN_ALL,
                seg:    {7'b0100100, 7'b0010010, 7'b1111001, 7'b0000000},
                an_nb: AN_ALL,
                seg_nb: {7'b0100100, 7'b0010010, 7'b1111001, 7'b0000000},
                seg_ah: {7'b1011011, 7'b1101101, 7'b0000110, 7'b1111111}};
    // Zero tens digits: blanked on the main variant, shown as 0 without blanking
    rows[1] = '{d: {4'd0, 4'd5, 4'd0, 4'd8}, an: {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                seg:    {7'b1111111, 7'b0010010, 7'b1111111, 7'b0000000},
                an_nb: AN_ALL,
                seg_nb: {7'b1000000, 7'b0010010, 7'b1000000, 7'b0000000},
                seg_ah: {7'b0000000, 7'b1101101, 7'b0000000, 7'b1111111}};
    // Out-of-range digit 12 shows a dash
    rows[2] = '{d: {4'd2, 4'd12, 4'd1, 4'd8}, an: AN_ALL,
                seg:    {7'b0100100, 7'b0111111, 7'b1111001, 7'b0000000},
                an_nb: AN_ALL,
                seg_nb: {7'b0100100, 7'b0111111, 7'b1111001, 7'b0000000},
                seg_ah: {7'b1011011, 7'b1000000, 7'b0000110, 7'b1111111}};
    rows[3] = '{d: {4'd9, 4'd7, 4'd4, 4'd6}, an: AN_ALL,
                seg:    {7'b0010000, 7'b1111000, 7'b0011001, 7'b0000010},
                an_nb: AN_ALL,
                seg_nb: {7'b0010000, 7'b1111000, 7'b0011001, 7'b0000010},
                seg_ah: {7'b1101111, 7'b0000111, 7'b1100110, 7'b1111101}};
    // Zero in ones positions is never blanked; 10 and 15 are dashes, not blanks
    rows[4] = '{d: {4'd15, 4'd0, 4'd10, 4'd0}, an: AN_ALL,
                seg:    {7'b0111111, 7'b1000000, 7'b0111111, 7'b1000000},
                an_nb: AN_ALL,
                seg_nb: {7'b0111111, 7'b1000000, 7'b0111111, 7'b1000000},
                seg_ah: {7'b1000000, 7'b0111111, 7'b1000000, 7'b0111111}};

    rnew = rows[0];
    rnew.d[0]      = 4'd3;
    rnew.seg[0]    = 7'b0110000;
    rnew.seg_nb[0] = 7'b0110000;
    rnew.seg_ah[0] = 7'b1001111;

    rst_n = 1'b1; enable = 1'b0;
    d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    #9 rst_n = 1'b1;
    step();

    for (int r = 0; r < 5; r++) begin
      enable = 1'b0;
      repeat (3) step();
      drive(rows[r]);
      enable = 1'b1;
      push_blank(2);
      push_frame(rows[r]);
      push_frame(rows[r]);
      drain(sb_q.size());
    end

    // Snapshot: d0 changes while slot 2 is scanning; new value only after the wrap
    enable = 1'b0;
    repeat (3) step();
    drive(rows[0]);
    enable = 1'b1;
    push_blank(2);
    push_frame(rows[0]);
    push_frame(rnew);
    drain(11);
    d0 = 4'd3;
    drain(sb_q.size());

    // Disable in slot 2, change d0 while off, re-enable
    enable = 1'b0;
    repeat (3) step();
    drive(rows[0]);
    enable = 1'b1;
    push_blank(2);
    for (int k = 0; k < 10; k++) push_entry(rows[0], k / 4, 1'b0);
    drain(sb_q.size());
    enable = 1'b0;
    d0 = 4'd3;
    push_entry(rows[0], 2, 1'b0);
    push_blank(3);
    drain(sb_q.size());
    enable = 1'b1;
    push_blank(2);
    for (int k = 0; k < 4; k++) push_entry(rnew, 0, 1'b0);
    push_entry(rnew, 1, 1'b0);
    drain(sb_q.size());

    // Asynchronous reset between clock edges while scanning
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    #2 rst_n = 1'b1;
    push_blank(2);
    push_frame(rnew);
    drain(sb_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
